// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / branch hazard detection.
// Computes the ID-stage destination, Tnew and Tuse values, raises a
// combinational stall against the producers held in EX and MEM, and inserts
// a bubble into EX while stalled. MEM-stage destination/Tnew tracking lives
// here as well so the hazard check sees both older producers.
// Optional feature: define STALL_COUNT_EN to add a saturating stall counter.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [10:0] id_ctrl,
    input  logic        id_branch_reg,
    input  logic        id_branch_ext32,
    output logic        stall,
    output logic [10:0] ex_ctrl,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_a3,
    output logic [4:0]  mem_a3,
    output logic [1:0]  ex_tnew,
    output logic [1:0]  mem_tnew
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    // Hazard against one older producer: source is live, matches, and the
    // value will not exist in time for when this instruction needs it.
    function automatic logic dep_hazard(input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input logic [4:0] dst,
                                        input logic [1:0] tnew);
        return (src != 5'd0) && (src == dst) && (tuse < tnew);
    endfunction

    logic [4:0]  rs_s, rt_s, rd_s, a3_s;
    logic [1:0]  reg_dst_s, mem_to_reg_s;
    logic        reg_write_s, mem_read_s, mem_write_s;
    logic [1:0]  tnew_s, tuse_rs_s, tuse_rt_s;
    logic        hazard_rs_s, hazard_rt_s;

    logic [10:0] ex_ctrl_r;
    logic [31:0] ex_pc_r, ex_rs_data_r, ex_rt_data_r, ex_imm_r;
    logic [4:0]  ex_a3_r, mem_a3_r;
    logic [1:0]  ex_tnew_r, mem_tnew_r;

    assign rs_s         = id_instr[25:21];
    assign rt_s         = id_instr[20:16];
    assign rd_s         = id_instr[15:11];
    assign reg_dst_s    = id_ctrl[7:6];
    assign reg_write_s  = id_ctrl[4];
    assign mem_read_s   = id_ctrl[3];
    assign mem_write_s  = id_ctrl[2];
    assign mem_to_reg_s = id_ctrl[1:0];

    // Decode destination register, result latency and operand-use times.
    always_comb begin
        a3_s      = 5'd0;
        tnew_s    = 2'd0;
        tuse_rs_s = 2'd1;
        tuse_rt_s = 2'd1;
        if (reg_write_s) begin
            case (reg_dst_s)
                2'b00:   a3_s = rt_s;
                2'b01:   a3_s = rd_s;
                2'b10:   a3_s = 5'd31;
                default: a3_s = 5'd0;
            endcase
        end else begin
            a3_s = 5'd0;
        end
        if (mem_read_s) begin
            tnew_s = 2'd2;
        end else if (mem_to_reg_s == 2'b10) begin
            tnew_s = 2'd0;      // jal: link value is ready in ID
        end else if (reg_write_s) begin
            tnew_s = 2'd1;
        end else begin
            tnew_s = 2'd0;
        end
        if (id_branch_reg || id_branch_ext32) begin
            tuse_rs_s = 2'd0;
        end else begin
            tuse_rs_s = 2'd1;
        end
        if (id_branch_ext32) begin
            tuse_rt_s = 2'd0;
        end else if (mem_write_s) begin
            tuse_rt_s = 2'd2;   // store data is only needed in MEM
        end else begin
            tuse_rt_s = 2'd1;
        end
    end

    // Stall when either source depends on an unfinished EX or MEM producer.
    always_comb begin
        hazard_rs_s = dep_hazard(rs_s, tuse_rs_s, ex_a3_r, ex_tnew_r) ||
                      dep_hazard(rs_s, tuse_rs_s, mem_a3_r, mem_tnew_r);
        hazard_rt_s = dep_hazard(rt_s, tuse_rt_s, ex_a3_r, ex_tnew_r) ||
                      dep_hazard(rt_s, tuse_rt_s, mem_a3_r, mem_tnew_r);
    end

    assign stall = hazard_rs_s || hazard_rt_s;

    // ID/EX register: load the ID instruction, or a bubble while stalled;
    // the EX producer always advances into the MEM tracking slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl_r    <= 11'd0;
            ex_pc_r      <= 32'd0;
            ex_rs_data_r <= 32'd0;
            ex_rt_data_r <= 32'd0;
            ex_imm_r     <= 32'd0;
            ex_a3_r      <= 5'd0;
            ex_tnew_r    <= 2'd0;
            mem_a3_r     <= 5'd0;
            mem_tnew_r   <= 2'd0;
        end else begin
            if (stall) begin
                ex_ctrl_r    <= 11'd0;
                ex_pc_r      <= 32'd0;
                ex_rs_data_r <= 32'd0;
                ex_rt_data_r <= 32'd0;
                ex_imm_r     <= 32'd0;
                ex_a3_r      <= 5'd0;
                ex_tnew_r    <= 2'd0;
            end else begin
                ex_ctrl_r    <= id_ctrl;
                ex_pc_r      <= id_pc;
                ex_rs_data_r <= id_rs_data;
                ex_rt_data_r <= id_rt_data;
                ex_imm_r     <= id_imm;
                ex_a3_r      <= a3_s;
                ex_tnew_r    <= tnew_s;
            end
            mem_a3_r   <= ex_a3_r;
            mem_tnew_r <= (ex_tnew_r == 2'd0) ? 2'd0 : ex_tnew_r - 2'd1;
        end
    end

    assign ex_ctrl    = ex_ctrl_r;
    assign ex_pc      = ex_pc_r;
    assign ex_rs_data = ex_rs_data_r;
    assign ex_rt_data = ex_rt_data_r;
    assign ex_imm     = ex_imm_r;
    assign ex_a3      = ex_a3_r;
    assign ex_tnew    = ex_tnew_r;
    assign mem_a3     = mem_a3_r;
    assign mem_tnew   = mem_tnew_r;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_count_r;

    // Count stalled edges, holding at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_r <= 32'd0;
        end else if (stall && (stall_count_r != 32'hFFFF_FFFF)) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a directed vector table covering the
// documented hazard scenarios, followed by randomized stimulus checked
// against a producer-readiness model (absolute ready times per pipeline slot).
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_instr, id_pc, id_rs_data, id_rt_data, id_imm;
    logic [10:0] id_ctrl;
    logic        id_branch_reg, id_branch_ext32;
    logic        stall;
    logic [10:0] ex_ctrl;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_a3, mem_a3;
    logic [1:0]  ex_tnew, mem_tnew;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_branch_reg(id_branch_reg),
        .id_branch_ext32(id_branch_ext32), .stall(stall), .ex_ctrl(ex_ctrl),
        .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_a3(ex_a3), .mem_a3(mem_a3), .ex_tnew(ex_tnew),
        .mem_tnew(mem_tnew)
`ifdef STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    // {ALUop, RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg}
    localparam logic [10:0] C_LW   = 11'b000_00_1_1_1_0_01;
    localparam logic [10:0] C_BEQ  = 11'b001_00_0_0_0_0_00;
    localparam logic [10:0] C_ADDU = 11'b010_01_0_1_0_0_00;
    localparam logic [10:0] C_SW   = 11'b000_00_1_0_0_1_00;
    localparam logic [10:0] C_ORI  = 11'b011_00_1_1_0_0_00;
    localparam logic [10:0] C_JAL  = 11'b000_10_0_1_0_0_10;
    localparam logic [10:0] C_NOP  = 11'b000_00_0_0_0_0_00;
    localparam logic [10:0] C_RD3  = 11'b010_11_0_1_0_0_00;

    typedef struct {
        logic        rst;
        logic [4:0]  rs, rt, rd;
        logic [10:0] ctrl;
        logic        br_reg, br_ext;
        logic [31:0] pc;
        logic        exp_stall;
        logic [4:0]  exp_ex_a3;
        logic [1:0]  exp_ex_tnew;
        logic [4:0]  exp_mem_a3;
        logic [1:0]  exp_mem_tnew;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mkv(logic rst, logic [4:0] rs, logic [4:0] rt,
                                 logic [4:0] rd, logic [10:0] ctrl,
                                 logic br_reg, logic br_ext, logic [31:0] pc,
                                 logic es, logic [4:0] ea3, logic [1:0] et,
                                 logic [4:0] ma3, logic [1:0] mt);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.rd = rd; v.ctrl = ctrl;
        v.br_reg = br_reg; v.br_ext = br_ext; v.pc = pc;
        v.exp_stall = es; v.exp_ex_a3 = ea3; v.exp_ex_tnew = et;
        v.exp_mem_a3 = ma3; v.exp_mem_tnew = mt;
        return v;
    endfunction

    function automatic logic [31:0] mk_instr(logic [4:0] rs, logic [4:0] rt,
                                             logic [4:0] rd);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (random phase) ----------------
    // Each pipeline slot remembers its destination and the absolute cycle at
    // which its result becomes available; Tnew is the time left until then.
    int          cyc;
    logic [4:0]  slot_dst[2];     // 0 = EX, 1 = MEM
    int          slot_ready[2];
    logic [10:0] m_ctrl;
    logic [31:0] m_pc, m_rsd, m_rtd, m_imm;
    longint      m_cnt;

    function automatic int left(int ready);
        return (ready > cyc) ? ready - cyc : 0;
    endfunction

    function automatic logic [4:0] ref_dest(logic [31:0] ins, logic [10:0] c);
        if (c[4] == 1'b0) return 5'd0;
        if (c[7:6] == 2'b00) return ins[20:16];
        if (c[7:6] == 2'b01) return ins[15:11];
        if (c[7:6] == 2'b10) return 5'd31;
        return 5'd0;
    endfunction

    function automatic int ref_tnew(logic [10:0] c);
        if (c[3]) return 2;
        if (c[1:0] == 2'b10) return 0;
        if (c[4]) return 1;
        return 0;
    endfunction

    function automatic logic ref_needs_wait(logic [4:0] src, int tuse);
        if (src == 5'd0) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (slot_dst[k] == src && tuse < left(slot_ready[k])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [4:0] rand_reg();
        int r = $urandom_range(0, 5);
        return (r == 5) ? 5'd31 : r[4:0];
    endfunction

    initial begin
        logic bubble;
        tbl[0]  = mkv(1, 2, 1, 0, C_LW,   0, 0, 32'h100, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 2, 1, 0, C_LW,   0, 0, 32'h100, 0, 1, 2, 0, 0);
        tbl[2]  = mkv(0, 1, 2, 0, C_BEQ,  0, 1, 32'h104, 1, 0, 0, 1, 1);
        tbl[3]  = mkv(0, 1, 2, 0, C_BEQ,  0, 1, 32'h104, 1, 0, 0, 0, 0);
        tbl[4]  = mkv(0, 1, 2, 0, C_BEQ,  0, 1, 32'h104, 0, 0, 0, 0, 0);
        tbl[5]  = mkv(0, 1, 2, 3, C_ADDU, 0, 0, 32'h108, 0, 3, 1, 0, 0);
        tbl[6]  = mkv(0, 3, 5, 0, C_SW,   0, 0, 32'h10C, 0, 0, 0, 3, 0);
        tbl[7]  = mkv(0, 7, 4, 0, C_LW,   0, 0, 32'h110, 0, 4, 2, 0, 0);
        tbl[8]  = mkv(0, 6, 4, 0, C_SW,   0, 0, 32'h114, 0, 0, 0, 4, 1);
        tbl[9]  = mkv(0, 0, 0, 0, C_ORI,  0, 0, 32'h118, 0, 0, 1, 0, 0);
        tbl[10] = mkv(0, 0, 0, 0, C_BEQ,  0, 1, 32'h11C, 0, 0, 0, 0, 0);
        tbl[11] = mkv(0, 0, 0, 0, C_JAL,  0, 0, 32'h120, 0, 31, 0, 0, 0);
        tbl[12] = mkv(0, 31, 0, 0, C_NOP, 1, 0, 32'h124, 0, 0, 0, 31, 0);
        tbl[13] = mkv(0, 2, 1, 0, C_LW,   0, 0, 32'h128, 0, 1, 2, 0, 0);
        tbl[14] = mkv(1, 1, 2, 0, C_BEQ,  0, 1, 32'h12C, 1, 0, 0, 0, 0);
        tbl[15] = mkv(0, 1, 2, 0, C_BEQ,  0, 1, 32'h130, 0, 0, 0, 0, 0);
        tbl[16] = mkv(0, 0, 6, 5, C_RD3,  0, 0, 32'h134, 0, 0, 1, 0, 0);

        reset = 1'b1; id_instr = 32'd0; id_pc = 32'd0; id_rs_data = 32'd0;
        id_rt_data = 32'd0; id_imm = 32'd0; id_ctrl = 11'd0;
        id_branch_reg = 1'b0; id_branch_ext32 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // ---------------- directed table ----------------
        for (int i = 0; i < 17; i++) begin
            reset           = tbl[i].rst;
            id_instr        = mk_instr(tbl[i].rs, tbl[i].rt, tbl[i].rd);
            id_ctrl         = tbl[i].ctrl;
            id_branch_reg   = tbl[i].br_reg;
            id_branch_ext32 = tbl[i].br_ext;
            id_pc           = tbl[i].pc;
            id_rs_data      = 32'hA000_0000 + i;
            id_rt_data      = 32'hB000_0000 + i;
            id_imm          = 32'hC000_0000 + i;
            #1;
            check($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, tbl[i].exp_stall});
            @(posedge clk); #1;
            bubble = tbl[i].rst | tbl[i].exp_stall;
            check($sformatf("v%0d ex_a3", i), {27'd0, ex_a3}, {27'd0, tbl[i].exp_ex_a3});
            check($sformatf("v%0d ex_tnew", i), {30'd0, ex_tnew}, {30'd0, tbl[i].exp_ex_tnew});
            check($sformatf("v%0d mem_a3", i), {27'd0, mem_a3}, {27'd0, tbl[i].exp_mem_a3});
            check($sformatf("v%0d mem_tnew", i), {30'd0, mem_tnew}, {30'd0, tbl[i].exp_mem_tnew});
            check($sformatf("v%0d ex_ctrl", i), {21'd0, ex_ctrl}, bubble ? 32'd0 : {21'd0, tbl[i].ctrl});
            check($sformatf("v%0d ex_pc", i), ex_pc, bubble ? 32'd0 : tbl[i].pc);
            check($sformatf("v%0d ex_rs_data", i), ex_rs_data, bubble ? 32'd0 : 32'hA000_0000 + i);
            check($sformatf("v%0d ex_rt_data", i), ex_rt_data, bubble ? 32'd0 : 32'hB000_0000 + i);
            check($sformatf("v%0d ex_imm", i), ex_imm, bubble ? 32'd0 : 32'hC000_0000 + i);
`ifdef STALL_COUNT_EN
            if (i == 3)  check("stall_count after lw/beq", stall_count, 32'd2);
            if (i == 14) check("stall_count after reset", stall_count, 32'd0);
`endif
            @(negedge clk);
        end

        // ---------------- randomized phase ----------------
        reset = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        for (int k = 0; k < 2; k++) begin slot_dst[k] = 5'd0; slot_ready[k] = 0; end
        m_ctrl = 11'd0; m_pc = 32'd0; m_rsd = 32'd0; m_rtd = 32'd0; m_imm = 32'd0;
        m_cnt = 0;
        @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            logic        rst_v, exp_stall;
            int          tuse_rs, tuse_rt;
            reset           = ($urandom_range(0, 31) == 0);
            rst_v           = reset;
            id_instr        = mk_instr(rand_reg(), rand_reg(), rand_reg());
            id_ctrl         = 11'($urandom_range(0, 2047));
            id_branch_reg   = ($urandom_range(0, 3) == 0);
            id_branch_ext32 = ($urandom_range(0, 3) == 0);
            id_pc           = $urandom;
            id_rs_data      = $urandom;
            id_rt_data      = $urandom;
            id_imm          = $urandom;
            #1;
            tuse_rs = (id_branch_reg || id_branch_ext32) ? 0 : 1;
            tuse_rt = id_branch_ext32 ? 0 : (id_ctrl[2] ? 2 : 1);
            exp_stall = ref_needs_wait(id_instr[25:21], tuse_rs) ||
                        ref_needs_wait(id_instr[20:16], tuse_rt);
            check($sformatf("r%0d stall", n), {31'd0, stall}, {31'd0, exp_stall});
            @(posedge clk); #1;
            cyc++;
            if (rst_v) begin
                slot_dst[1] = 5'd0; slot_ready[1] = cyc;
                slot_dst[0] = 5'd0; slot_ready[0] = cyc;
                m_ctrl = 11'd0; m_pc = 32'd0; m_rsd = 32'd0; m_rtd = 32'd0; m_imm = 32'd0;
                m_cnt = 0;
            end else begin
                slot_dst[1] = slot_dst[0]; slot_ready[1] = slot_ready[0];
                if (exp_stall) begin
                    slot_dst[0] = 5'd0; slot_ready[0] = cyc;
                    m_ctrl = 11'd0; m_pc = 32'd0; m_rsd = 32'd0; m_rtd = 32'd0; m_imm = 32'd0;
                    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                end else begin
                    slot_dst[0] = ref_dest(id_instr, id_ctrl);
                    slot_ready[0] = cyc + ref_tnew(id_ctrl);
                    m_ctrl = id_ctrl; m_pc = id_pc; m_rsd = id_rs_data;
                    m_rtd = id_rt_data; m_imm = id_imm;
                end
            end
            check($sformatf("r%0d ex_ctrl", n), {21'd0, ex_ctrl}, {21'd0, m_ctrl});
            check($sformatf("r%0d ex_pc", n), ex_pc, m_pc);
            check($sformatf("r%0d ex_rs_data", n), ex_rs_data, m_rsd);
            check($sformatf("r%0d ex_rt_data", n), ex_rt_data, m_rtd);
            check($sformatf("r%0d ex_imm", n), ex_imm, m_imm);
            check($sformatf("r%0d ex_a3", n), {27'd0, ex_a3}, {27'd0, slot_dst[0]});
            check($sformatf("r%0d ex_tnew", n), {30'd0, ex_tnew}, 32'(left(slot_ready[0])));
            check($sformatf("r%0d mem_a3", n), {27'd0, mem_a3}, {27'd0, slot_dst[1]});
            check($sformatf("r%0d mem_tnew", n), {30'd0, mem_tnew}, 32'(left(slot_ready[1])));
`ifdef STALL_COUNT_EN
            check($sformatf("r%0d stall_count", n), stall_count, m_cnt[31:0]);
`endif
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
